// File: rtl/layer3_conv_sched_if.sv
// Bus bundle for the layer-3 conv scheduler: layer control, input buffer read,
// conv datapath handshake and output buffer write. conv_err exists with CONV_TIMEOUT_EN.
interface layer3_conv_sched_if #(
   parameter int BITS   = 16,
   parameter int CH_IN  = 8,
   parameter int CH_OUT = 16,
   parameter int ADDR_W = 6
);
   logic                     layer_start;
   logic                     busy;
   logic                     layer_done;
   logic                     in_rd_en;
   logic [ADDR_W-1:0]        in_rd_addr;
   logic [CH_IN*BITS-1:0]    in_rd_data;
   logic [CH_IN*BITS-1:0]    conv_data_in;
   logic                     conv_start;
   logic                     conv_ready;
   logic [CH_OUT*BITS-1:0]   conv_data_out;
   logic                     out_wr_en;
   logic [ADDR_W-1:0]        out_wr_addr;
   logic [CH_OUT*BITS-1:0]   out_wr_data;
   logic                     out_wr_rdy;
   logic [ADDR_W-1:0]        pix_idx;
`ifdef CONV_TIMEOUT_EN
   logic                     conv_err;
`endif

   modport master (
      input  layer_start, in_rd_data, conv_ready, conv_data_out, out_wr_rdy,
      output busy, layer_done, in_rd_en, in_rd_addr, conv_data_in, conv_start,
             out_wr_en, out_wr_addr, out_wr_data, pix_idx
`ifdef CONV_TIMEOUT_EN
      , output conv_err
`endif
   );

   modport slave (
      output layer_start, in_rd_data, conv_ready, conv_data_out, out_wr_rdy,
      input  busy, layer_done, in_rd_en, in_rd_addr, conv_data_in, conv_start,
             out_wr_en, out_wr_addr, out_wr_data, pix_idx
`ifdef CONV_TIMEOUT_EN
      , input conv_err
`endif
   );
endinterface

// File: rtl/layer3_conv_sched.sv
// Per-pixel sequencer for the layer-3 1x1 conv: fetch, load, start, wait, capture, write.
// Optional CONV_TIMEOUT_EN adds a WAIT watchdog with a sticky conv_err flag.
module layer3_conv_sched #(
   parameter int BITS    = 16,
   parameter int CH_IN   = 8,
   parameter int CH_OUT  = 16,
   parameter int PIXELS  = 64,
   parameter int ADDR_W  = 6
`ifdef CONV_TIMEOUT_EN
   , parameter int TIMEOUT = 255
`endif
) (
   input  logic                 clk_in,
   input  logic                 rst_n,   // active-high despite the name
   layer3_conv_sched_if.master  bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_LOAD, S_START, S_WAIT, S_CAPTURE, S_WRITE, S_DONE
   } state_e;

   state_e                   state_q, state_d;
   logic [ADDR_W-1:0]        pix_idx_q, pix_idx_d;
   logic                     busy_q, busy_d;
   logic [CH_IN*BITS-1:0]    conv_data_in_q, conv_data_in_d;
   logic [ADDR_W-1:0]        out_wr_addr_q, out_wr_addr_d;
   logic [CH_OUT*BITS-1:0]   out_wr_data_q, out_wr_data_d;
   logic                     last_pix;

   assign last_pix = (pix_idx_q == ADDR_W'(PIXELS-1));

`ifdef CONV_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT > 255) ? $clog2(TIMEOUT+1) : 8;
   logic [TO_W-1:0]          wd_cnt_q, wd_cnt_d;
   logic                     conv_err_q, conv_err_d;
   logic                     wd_expired;

   assign wd_expired = (wd_cnt_q == TO_W'(TIMEOUT-1));
`endif

   always_ff @(posedge clk_in or posedge rst_n) begin
      if (rst_n) begin
         state_q        <= S_IDLE;
         pix_idx_q      <= '0;
         busy_q         <= 1'b0;
         conv_data_in_q <= '0;
         out_wr_addr_q  <= '0;
         out_wr_data_q  <= '0;
`ifdef CONV_TIMEOUT_EN
         wd_cnt_q       <= '0;
         conv_err_q     <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         pix_idx_q      <= pix_idx_d;
         busy_q         <= busy_d;
         conv_data_in_q <= conv_data_in_d;
         out_wr_addr_q  <= out_wr_addr_d;
         out_wr_data_q  <= out_wr_data_d;
`ifdef CONV_TIMEOUT_EN
         wd_cnt_q       <= wd_cnt_d;
         conv_err_q     <= conv_err_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:    if (bus.layer_start) state_d = S_FETCH;
         S_FETCH:   state_d = S_LOAD;
         S_LOAD:    state_d = S_START;
         S_START:   state_d = S_WAIT;
         S_WAIT: begin
            if (bus.conv_ready) state_d = S_CAPTURE;
`ifdef CONV_TIMEOUT_EN
            else if (wd_expired) state_d = S_IDLE;
`endif
         end
         S_CAPTURE: state_d = S_WRITE;
         S_WRITE:   if (bus.out_wr_rdy) state_d = last_pix ? S_DONE : S_FETCH;
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Datapath registers; conv_data_in only changes in LOAD so it is stable through CAPTURE.
   always_comb begin
      pix_idx_d      = pix_idx_q;
      busy_d         = busy_q;
      conv_data_in_d = conv_data_in_q;
      out_wr_addr_d  = out_wr_addr_q;
      out_wr_data_d  = out_wr_data_q;
`ifdef CONV_TIMEOUT_EN
      wd_cnt_d       = wd_cnt_q;
      conv_err_d     = conv_err_q;
`endif
      unique case (state_q)
         S_IDLE: if (bus.layer_start) begin
            pix_idx_d = '0;
            busy_d    = 1'b1;
         end
         S_LOAD:    conv_data_in_d = bus.in_rd_data;
`ifdef CONV_TIMEOUT_EN
         S_START:   wd_cnt_d = '0;
         S_WAIT: if (!bus.conv_ready) begin
            if (wd_expired) begin
               conv_err_d = 1'b1;
               busy_d     = 1'b0;
            end else begin
               wd_cnt_d = wd_cnt_q + 1'b1;
            end
         end
`endif
         S_CAPTURE: begin
            out_wr_data_d = bus.conv_data_out;
            out_wr_addr_d = pix_idx_q;
         end
         S_WRITE: if (bus.out_wr_rdy && !last_pix) pix_idx_d = pix_idx_q + 1'b1;
         S_DONE: begin
            busy_d    = 1'b0;
            pix_idx_d = '0;
         end
         default: ;
      endcase
   end

   always_comb begin
      bus.busy         = busy_q;
      bus.in_rd_en     = (state_q == S_FETCH);
      bus.in_rd_addr   = (state_q == S_FETCH) ? pix_idx_q : '0;
      bus.conv_data_in = conv_data_in_q;
      bus.conv_start   = (state_q == S_START);
      bus.out_wr_en    = (state_q == S_WRITE);
      bus.out_wr_addr  = out_wr_addr_q;
      bus.out_wr_data  = out_wr_data_q;
      bus.layer_done   = (state_q == S_DONE);
      bus.pix_idx      = pix_idx_q;
`ifdef CONV_TIMEOUT_EN
      bus.conv_err     = conv_err_q;
`endif
   end

endmodule

// File: tb/tb_layer3_conv_sched.sv
// Directed bench for layer3_conv_sched: input RAM, conv datapath and output RAM models
// plus a write scoreboard; timeout scenario only with CONV_TIMEOUT_EN.
module tb_layer3_conv_sched;
   localparam int BITS = 16, CH_IN = 8, CH_OUT = 16, PIXELS = 64, ADDR_W = 6;

   logic clk_in = 1'b0;
   logic rst_n  = 1'b1;
   always #5 clk_in = ~clk_in;

   layer3_conv_sched_if #(.BITS(BITS), .CH_IN(CH_IN), .CH_OUT(CH_OUT), .ADDR_W(ADDR_W)) bus ();

   layer3_conv_sched #(
      .BITS(BITS), .CH_IN(CH_IN), .CH_OUT(CH_OUT), .PIXELS(PIXELS), .ADDR_W(ADDR_W)
`ifdef CONV_TIMEOUT_EN
      , .TIMEOUT(16)
`endif
   ) dut (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   int n_cmp = 0, n_err = 0;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] pix_word(input int a, input int c);
      return 16'((a << 8) | (c << 4) | 5);
   endfunction

   function automatic logic [127:0] pix_vec(input int a);
      logic [127:0] v;
      for (int c = 0; c < CH_IN; c++) v[c*16 +: 16] = pix_word(a, c);
      return v;
   endfunction

   // Datapath transfer: out[j] = in[j%8] + 3j+1
   function automatic logic [255:0] conv_f(input logic [127:0] v);
      logic [255:0] r;
      for (int j = 0; j < CH_OUT; j++) r[j*16 +: 16] = v[(j%8)*16 +: 16] + 16'(3*j + 1);
      return r;
   endfunction

   function automatic logic [255:0] exp_out(input int a);
      logic [255:0] r;
      for (int j = 0; j < CH_OUT; j++) r[j*16 +: 16] = pix_word(a, j%8) + 16'(3*j + 1);
      return r;
   endfunction

   // Environment models
   int  cyc = 0;
   int  wcnt = 0;
   int  ready_dly = 1;
   bit  stuck_en = 0;

   always @(posedge clk_in) cyc <= cyc + 1;

   always @(posedge clk_in) begin
      if (bus.in_rd_en) bus.in_rd_data <= pix_vec(int'(bus.in_rd_addr));
      if (bus.conv_ready) bus.conv_data_out <= conv_f(bus.conv_data_in);
      if (bus.conv_start) wcnt <= 1;
      else if (wcnt != 0) wcnt <= wcnt + 1;
   end

   assign bus.conv_ready = (wcnt != 0) && (wcnt >= ready_dly) &&
                           !(stuck_en && bus.pix_idx == ADDR_W'(3));

   // Output RAM responder and scoreboard
   bit  stall_en = 0;
   int  stall_cnt = 0;
   int  hold_cnt = 0;
   int  wr_cnt = 0, rd_cnt = 0, cs_cnt = 0, done_cnt = 0;
   int  rd0_cyc = -1, done_cyc = -1, err_cyc = -1, last_cs_cyc = -1;
   int  overlap_cnt = 0, b2b_cnt = 0;
   bit  prev_cs = 0;

   always @(negedge clk_in) begin
      if (bus.out_wr_en && stall_en && bus.out_wr_addr == ADDR_W'(5) && stall_cnt < 10) begin
         bus.out_wr_rdy = 1'b0;
         stall_cnt++;
      end else begin
         bus.out_wr_rdy = 1'b1;
      end
      if (stall_en && bus.out_wr_en && bus.out_wr_addr == ADDR_W'(5) &&
          bus.out_wr_data == exp_out(5))
         hold_cnt++;
      if (bus.out_wr_en && bus.out_wr_rdy) begin
         chk("wr_addr", 256'(bus.out_wr_addr), 256'(wr_cnt));
         chk("wr_data", bus.out_wr_data, exp_out(wr_cnt));
         wr_cnt++;
      end
      if (bus.in_rd_en) begin
         if (rd0_cyc < 0) rd0_cyc = cyc;
         rd_cnt++;
      end
      if (bus.in_rd_en && bus.out_wr_en) overlap_cnt++;
      if (bus.conv_start) begin
         cs_cnt++;
         last_cs_cyc = cyc;
         if (prev_cs) b2b_cnt++;
      end
      prev_cs = bus.conv_start;
      if (bus.layer_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
`ifdef CONV_TIMEOUT_EN
      if (bus.conv_err && err_cyc < 0) err_cyc = cyc;
`endif
   end

   task automatic new_pass();
      wr_cnt = 0; rd_cnt = 0; cs_cnt = 0;
      rd0_cyc = -1; done_cyc = -1;
   endtask

   task automatic start_layer();
      @(negedge clk_in) bus.layer_start = 1'b1;
      @(negedge clk_in) bus.layer_start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int d0;
      bit ok;
      d0 = done_cnt;
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk_in);
         if (done_cnt != d0) begin ok = 1; break; end
      end
      chk(tag, 256'(ok), 256'(1));
   endtask

   task automatic wait_pix(input string tag, input int p, input bit need_cs, input int budget);
      bit ok;
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk_in);
         #1;
         if (bus.pix_idx == ADDR_W'(p) && (!need_cs || bus.conv_start)) begin ok = 1; break; end
      end
      chk(tag, 256'(ok), 256'(1));
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_busy"},  256'(bus.busy), 256'(0));
      chk({tag, "_done"},  256'(bus.layer_done), 256'(0));
      chk({tag, "_rd"},    256'({bus.in_rd_en, bus.in_rd_addr}), 256'(0));
      chk({tag, "_cs"},    256'(bus.conv_start), 256'(0));
      chk({tag, "_wr"},    256'({bus.out_wr_en, bus.out_wr_addr}), 256'(0));
      chk({tag, "_pix"},   256'(bus.pix_idx), 256'(0));
      chk({tag, "_cdin"},  256'(bus.conv_data_in), 256'(0));
      chk({tag, "_wdata"}, bus.out_wr_data, 256'(0));
   endtask

   initial begin
      int d0;
      bus.layer_start = 1'b0;
      bus.in_rd_data  = '0;
      bus.conv_data_out = '0;
      bus.out_wr_rdy  = 1'b1;

      // Reset state
      repeat (3) @(negedge clk_in);
      #1 chk_idle_outputs("rst");
      @(negedge clk_in) rst_n = 1'b0;
      repeat (2) @(negedge clk_in);

      // 1: nominal pass, ready after one WAIT cycle
      new_pass();
      start_layer();
      wait_done("t1_done", 1000);
      @(negedge clk_in); #1;
      chk("t1_writes", 256'(wr_cnt), 256'(64));
      chk("t1_reads", 256'(rd_cnt), 256'(64));
      chk("t1_latency", 256'(done_cyc - rd0_cyc), 256'(384));
      chk("t1_busy_after", 256'(bus.busy), 256'(0));
      chk("t1_done_cnt", 256'(done_cnt), 256'(1));

      // 2: 10-cycle back-pressure on pixel 5
      new_pass();
      stall_en = 1; stall_cnt = 0; hold_cnt = 0;
      start_layer();
      wait_done("t2_done", 1000);
      @(negedge clk_in); #1;
      stall_en = 0;
      chk("t2_hold_cycles", 256'(hold_cnt), 256'(11));
      chk("t2_writes", 256'(wr_cnt), 256'(64));
      chk("t2_reads", 256'(rd_cnt), 256'(64));
      chk("t2_latency", 256'(done_cyc - rd0_cyc), 256'(394));

      // 3: layer_start while busy at pixel 20 is ignored
      new_pass();
      d0 = done_cnt;
      start_layer();
      wait_pix("t3_reach20", 20, 0, 500);
      start_layer();
      wait_done("t3_done", 1000);
      repeat (20) @(negedge clk_in);
      #1;
      chk("t3_done_once", 256'(done_cnt - d0), 256'(1));
      chk("t3_writes", 256'(wr_cnt), 256'(64));
      chk("t3_busy_after", 256'(bus.busy), 256'(0));

      // 4: reset during WAIT of pixel 30, then a clean pass
      new_pass();
      d0 = done_cnt;
      start_layer();
      wait_pix("t4_reach30", 30, 1, 500);
      @(negedge clk_in) rst_n = 1'b1;
      #1 chk_idle_outputs("t4_rst");
      repeat (3) @(negedge clk_in);
      #1 chk_idle_outputs("t4_rst_hold");
      rst_n = 1'b0;
      chk("t4_partial_writes", 256'(wr_cnt), 256'(30));
      repeat (10) @(negedge clk_in);
      chk("t4_no_done", 256'(done_cnt - d0), 256'(0));
      new_pass();
      start_layer();
      wait_done("t4_done", 1000);
      @(negedge clk_in); #1;
      chk("t4_writes", 256'(wr_cnt), 256'(64));
      chk("t4_latency", 256'(done_cyc - rd0_cyc), 256'(384));

      // 5: ready delayed 7 WAIT cycles on every pixel
      new_pass();
      ready_dly = 7;
      b2b_cnt = 0;
      start_layer();
      wait_done("t5_done", 2000);
      @(negedge clk_in); #1;
      chk("t5_starts", 256'(cs_cnt), 256'(64));
      chk("t5_latency", 256'(done_cyc - rd0_cyc), 256'(768));
      chk("t5_writes", 256'(wr_cnt), 256'(64));
      ready_dly = 1;

`ifdef CONV_TIMEOUT_EN
      // 6: datapath hangs on pixel 3
      begin
         bit ok;
         new_pass();
         d0 = done_cnt;
         stuck_en = 1;
         err_cyc = -1;
         start_layer();
         ok = 0;
         for (int i = 0; i < 500; i++) begin
            @(negedge clk_in); #1;
            if (bus.conv_err) begin ok = 1; break; end
         end
         chk("t6_err_seen", 256'(ok), 256'(1));
         repeat (5) @(negedge clk_in);
         #1;
         chk("t6_err_sticky", 256'(bus.conv_err), 256'(1));
         chk("t6_err_timing", 256'(err_cyc - last_cs_cyc), 256'(17));
         chk("t6_writes", 256'(wr_cnt), 256'(3));
         chk("t6_busy", 256'(bus.busy), 256'(0));
         chk("t6_no_done", 256'(done_cnt - d0), 256'(0));
         stuck_en = 0;
      end
`endif

      chk("rd_wr_overlap", 256'(overlap_cnt), 256'(0));
      chk("cs_back_to_back", 256'(b2b_cnt), 256'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end
endmodule
